// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC and reads a combinational instruction memory.
// Returned words are queued with their PC in a 2-entry FIFO that feeds decode through valid/ready.
module instruction_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RESET_PC   = 0,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter bit WRAP = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  output logic [ADDR_WIDTH-1:0] ReadAddress,
  input  logic [DATA_WIDTH-1:0] Instruction,
  input  logic                  Redirect,
  input  logic [ADDR_WIDTH-1:0] RedirectAddr,
  output logic [DATA_WIDTH-1:0] InstrOut,
  output logic [ADDR_WIDTH-1:0] PCOut,
  output logic                  InstrValid,
  input  logic                  InstrReady,
  output logic                  Busy,
  output logic                  Halted
);

  localparam logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] LAST_PC  = '1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [1:0]            count_reg;
  logic                  head_reg;
  logic                  tail_reg;
  logic [DATA_WIDTH-1:0] instr_out_reg;
  logic [ADDR_WIDTH-1:0] pc_out_reg;

  logic [DATA_WIDTH-1:0] buf_instr [2];
  logic [ADDR_WIDTH-1:0] buf_pc    [2];

  logic       pop;
  logic       push;
  logic [1:0] count_next;
  logic [1:0] remain;
  logic       head_next;
  logic       halt_hit;
  logic       end_hit;

  assign pop        = (count_reg != 2'd0) && InstrReady;
  assign push       = (state_reg == FETCH) && !Redirect && ((count_reg != 2'd2) || pop);
  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};
  assign remain     = count_reg - {1'b0, pop};
  assign head_next  = head_reg ^ pop;
  assign halt_hit   = (Instruction == HALT_WORD);
  assign end_hit    = !WRAP && (pc_reg == LAST_PC);

  assign ReadAddress = pc_reg;
  assign InstrOut    = instr_out_reg;
  assign PCOut       = pc_out_reg;
  assign InstrValid  = (count_reg != 2'd0);
  assign Busy        = (state_reg == FETCH) || (state_reg == DRAIN);
  assign Halted      = (state_reg == HALT);

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[tail_reg] <= Instruction;
      buf_pc[tail_reg]    <= pc_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      pc_reg        <= START_PC;
      count_reg     <= 2'd0;
      head_reg      <= 1'b0;
      tail_reg      <= 1'b0;
      instr_out_reg <= '0;
      pc_out_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Redirect) pc_reg <= RedirectAddr;
          if (Start) state_reg <= FETCH;
        end
        FETCH, DRAIN: begin
          if (Redirect) begin
            // flush wins over any pop, halt or end-of-memory this cycle
            state_reg <= FETCH;
            pc_reg    <= RedirectAddr;
            count_reg <= 2'd0;
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
          end else begin
            count_reg <= count_next;
            head_reg  <= head_next;
            if (push) begin
              tail_reg <= ~tail_reg;
              if (halt_hit || end_hit) state_reg <= DRAIN;
              else pc_reg <= pc_reg + 1'b1;
            end
            if (state_reg == DRAIN && count_next == 2'd0) state_reg <= HALT;
            // head register follows the new head; the incoming word bypasses when nothing else remains
            if (count_next != 2'd0) begin
              instr_out_reg <= (remain == 2'd0) ? Instruction : buf_instr[head_next];
              pc_out_reg    <= (remain == 2'd0) ? pc_reg : buf_pc[head_next];
            end
          end
        end
        HALT: begin
          if (Start) begin
            state_reg <= FETCH;
            pc_reg    <= START_PC;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboarded bench: two units (stop-at-end and wrapping) share stimulus and an instruction memory image.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        Start;
  logic        Redirect;
  logic [4:0]  RedirectAddr;
  logic        InstrReady;

  logic [31:0] mem [32];

  logic [4:0]  ra0, pco0, ra1, pco1;
  logic [31:0] io0, io1, instr0, instr1;
  logic        v0, busy0, halt0, v1, busy1, halt1;

  assign instr0 = mem[ra0];
  assign instr1 = mem[ra1];

  instruction_fetch_unit #(.WRAP(1'b0)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ReadAddress(ra0), .Instruction(instr0),
    .Redirect(Redirect), .RedirectAddr(RedirectAddr), .InstrOut(io0), .PCOut(pco0),
    .InstrValid(v0), .InstrReady(InstrReady), .Busy(busy0), .Halted(halt0)
  );

  instruction_fetch_unit #(.WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .Start(Start), .ReadAddress(ra1), .Instruction(instr1),
    .Redirect(Redirect), .RedirectAddr(RedirectAddr), .InstrOut(io1), .PCOut(pco1),
    .InstrValid(v1), .InstrReady(InstrReady), .Busy(busy1), .Halted(halt1)
  );

  logic        sel_w;
  logic        mon_en;
  logic [4:0]  ra_s, pco_s;
  logic [31:0] io_s;
  logic        v_s, busy_s, halt_s;

  assign ra_s   = sel_w ? ra1   : ra0;
  assign pco_s  = sel_w ? pco1  : pco0;
  assign io_s   = sel_w ? io1   : io0;
  assign v_s    = sel_w ? v1    : v0;
  assign busy_s = sel_w ? busy1 : busy0;
  assign halt_s = sel_w ? halt1 : halt0;

  int n_vec;
  int n_err;
  logic [36:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: a transfer happens at the next edge when valid && ready and no redirect discards it.
  task automatic sb_pop_check();
    logic [36:0] e;
    if (mon_en && v_s && InstrReady && !Redirect) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_xfer got pc=%0d instr=%h want none", pco_s, io_s);
      end else begin
        e = exp_q.pop_front();
        if ({pco_s, io_s} !== e) begin
          n_err++;
          $display("FAIL xfer got pc=%0d instr=%h want pc=%0d instr=%h", pco_s, io_s, e[36:32], e[31:0]);
        end else begin
          $display("xfer pc=%0d instr=%h ok", pco_s, io_s);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_pop_check();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    Start = 1'b0;
    Redirect = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_range(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      int p;
      p = (first + i) % 32;
      exp_q.push_back({p[4:0], mem[p]});
    end
  endtask

  task automatic drain_queue(input string name, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout got %0d pending want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_vec++; if (v_s !== 1'b0)    begin n_err++; $display("FAIL reset_valid got %b want 0", v_s); end
    n_vec++; if (busy_s !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_s); end
    n_vec++; if (halt_s !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halt_s); end
    n_vec++; if (ra_s !== 5'd0)   begin n_err++; $display("FAIL reset_addr got %0d want 0", ra_s); end
    n_vec++; if (io_s !== 32'd0)  begin n_err++; $display("FAIL reset_instr got %h want 0", io_s); end
    n_vec++; if (pco_s !== 5'd0)  begin n_err++; $display("FAIL reset_pc got %0d want 0", pco_s); end
    do_reset();
  endtask

  task automatic test_sequential();
    int n;
    do_reset();
    InstrReady = 1'b1;
    push_range(0, 32);
    Start = 1'b1; tick(); Start = 1'b0;
    n_vec++; if (busy_s !== 1'b1) begin n_err++; $display("FAIL seq_busy got %b want 1", busy_s); end
    n_vec++; if (v_s !== 1'b0)    begin n_err++; $display("FAIL seq_valid_early got %b want 0", v_s); end
    tick();
    n_vec++; if (v_s !== 1'b1)    begin n_err++; $display("FAIL seq_first_valid got %b want 1", v_s); end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    n_vec++; if (n != 32)         begin n_err++; $display("FAIL seq_throughput got %0d cycles want 32", n); end
    n_vec++; if (halt_s !== 1'b1) begin n_err++; $display("FAIL seq_halted got %b want 1", halt_s); end
    n_vec++; if (ra_s !== 5'd31)  begin n_err++; $display("FAIL seq_addr_hold got %0d want 31", ra_s); end
    n_vec++; if (busy_s !== 1'b0) begin n_err++; $display("FAIL seq_busy_end got %b want 0", busy_s); end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    InstrReady = 1'b0;
    Start = 1'b1; tick(); Start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (v_s !== 1'b1)          begin n_err++; $display("FAIL bp_valid got %b want 1", v_s); end
      n_vec++; if (io_s !== 32'h0000_0100) begin n_err++; $display("FAIL bp_instr got %h want 00000100", io_s); end
    end
    n_vec++; if (ra_s !== 5'd2) begin n_err++; $display("FAIL bp_pc_stall got %0d want 2", ra_s); end
    push_range(0, 32);
    InstrReady = 1'b1;
    n = 0;
    while (halt_s !== 1'b1 && n < 100) begin tick(); n++; end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_pending got %0d want 0", exp_q.size()); end
    n_vec++; if (halt_s !== 1'b1)   begin n_err++; $display("FAIL bp_halted got %b want 1", halt_s); end
  endtask

  task automatic test_halt_word();
    do_reset();
    mem[5] = 32'hFFFF_FFFF;
    InstrReady = 1'b1;
    push_range(0, 6);
    Start = 1'b1; tick(); Start = 1'b0;
    drain_queue("halt", 40);
    n_vec++; if (halt_s !== 1'b1) begin n_err++; $display("FAIL halt_halted got %b want 1", halt_s); end
    for (int i = 0; i < 3; i++) tick();
    n_vec++; if (ra_s !== 5'd5)   begin n_err++; $display("FAIL halt_addr got %0d want 5", ra_s); end
    Start = 1'b1; tick(); Start = 1'b0;
    n_vec++; if (busy_s !== 1'b1) begin n_err++; $display("FAIL halt_restart_busy got %b want 1", busy_s); end
    n_vec++; if (ra_s !== 5'd0)   begin n_err++; $display("FAIL halt_restart_pc got %0d want 0", ra_s); end
    InstrReady = 1'b0;
    mem[5] = 32'h0000_0105;
    do_reset();
  endtask

  task automatic test_redirect();
    do_reset();
    InstrReady = 1'b1;
    push_range(0, 3);
    Start = 1'b1; tick(); Start = 1'b0;
    drain_queue("redir_pre", 20);
    InstrReady = 1'b0;
    tick(); tick();
    n_vec++; if (pco_s !== 5'd3) begin n_err++; $display("FAIL redir_head got %0d want 3", pco_s); end
    n_vec++; if (ra_s !== 5'd5)  begin n_err++; $display("FAIL redir_full_pc got %0d want 5", ra_s); end
    Redirect = 1'b1; RedirectAddr = 5'd12; tick(); Redirect = 1'b0;
    n_vec++; if (v_s !== 1'b0)   begin n_err++; $display("FAIL redir_flush got %b want 0", v_s); end
    n_vec++; if (ra_s !== 5'd12) begin n_err++; $display("FAIL redir_addr got %0d want 12", ra_s); end
    push_range(12, 2);
    InstrReady = 1'b1;
    drain_queue("redir_12", 20);
    // redirect together with a pop: the head entry must vanish too
    Redirect = 1'b1; RedirectAddr = 5'd20; tick(); Redirect = 1'b0;
    n_vec++; if (v_s !== 1'b0)   begin n_err++; $display("FAIL redir_pop_flush got %b want 0", v_s); end
    n_vec++; if (ra_s !== 5'd20) begin n_err++; $display("FAIL redir_pop_addr got %0d want 20", ra_s); end
    push_range(20, 2);
    drain_queue("redir_20", 20);
    InstrReady = 1'b0;
    do_reset();
  endtask

  task automatic test_wrap();
    sel_w = 1'b1;
    do_reset();
    InstrReady = 1'b0;
    Start = 1'b1; tick(); Start = 1'b0;
    tick(); tick();
    Redirect = 1'b1; RedirectAddr = 5'd30; tick(); Redirect = 1'b0;
    push_range(30, 5);
    InstrReady = 1'b1;
    drain_queue("wrap", 30);
    InstrReady = 1'b0;
    n_vec++; if (halt_s !== 1'b0) begin n_err++; $display("FAIL wrap_halted got %b want 0", halt_s); end
    n_vec++; if (busy_s !== 1'b1) begin n_err++; $display("FAIL wrap_busy got %b want 1", busy_s); end
    do_reset();
    sel_w = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    mon_en = 1'b0;
    InstrReady = 1'b1;
    Start = 1'b1; tick(); Start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    n_vec++; if (v_s !== 1'b0)    begin n_err++; $display("FAIL areset_valid got %b want 0", v_s); end
    n_vec++; if (busy_s !== 1'b0) begin n_err++; $display("FAIL areset_busy got %b want 0", busy_s); end
    n_vec++; if (ra_s !== 5'd0)   begin n_err++; $display("FAIL areset_addr got %0d want 0", ra_s); end
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_vec++; if (busy_s !== 1'b0) begin n_err++; $display("FAIL areset_idle_busy got %b want 0", busy_s); end
    n_vec++; if (v_s !== 1'b0)    begin n_err++; $display("FAIL areset_idle_valid got %b want 0", v_s); end
    n_vec++; if (halt_s !== 1'b0) begin n_err++; $display("FAIL areset_idle_halt got %b want 0", halt_s); end
    n_vec++; if (ra_s !== 5'd0)   begin n_err++; $display("FAIL areset_idle_addr got %0d want 0", ra_s); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    sel_w = 1'b0;
    mon_en = 1'b1;
    Start = 1'b0;
    Redirect = 1'b0;
    RedirectAddr = 5'd0;
    InstrReady = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;
    test_reset();
    test_sequential();
    test_backpressure();
    test_halt_word();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
